util_fifo_rle: RTL and testbench

UTIL_FIFO_RLE -- requirements
Module: util_fifo_rle

---
 rtl/util_fifo_rle.sv | 164 ++++++++++++++++
 tb/tb_util_fifo_rle.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/util_fifo_rle.sv
// util_fifo_rle: run-length encoding FIFO. Consecutive identical input words
// collapse into (data,count) entries held in a show-ahead FIFO. The open run
// is committed when a different word arrives, when the count saturates, or
// on flush.
// Optional build macro UTIL_FIFO_RLE_TIMEOUT_EN adds an idle counter that
// auto-commits the open run after TIMEOUT cycles without an accepted write.
module util_fifo_rle #(
    parameter int INPUT_WIDTH = 32,
    parameter int COUNT_WIDTH = 8,
    parameter int DEPTH       = 128,
    parameter int TIMEOUT     = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [INPUT_WIDTH-1:0]     din,
    input  logic                       wren,
    input  logic                       flush,
    output logic                       full,
    output logic [INPUT_WIDTH-1:0]     dout,
    output logic [COUNT_WIDTH-1:0]     dnum,
    input  logic                       rden,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     dcnt,
    output logic                       run_open
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = INPUT_WIDTH + COUNT_WIDTH;
    localparam logic [PW-1:0]          DEPTH_P = PW'(DEPTH);
    localparam logic [COUNT_WIDTH-1:0] RMAX    = {COUNT_WIDTH{1'b1}};
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

    logic [PW-1:0]          wptr_q, wptr_d;
    logic [PW-1:0]          rptr_q, rptr_d;
    logic [INPUT_WIDTH-1:0] run_data_q, run_data_d;
    logic [COUNT_WIDTH-1:0] run_cnt_q, run_cnt_d;
    logic                   run_open_q, run_open_d;
    logic [EW-1:0]          mem_q [DEPTH];

    logic [PW-1:0]          dcnt_s;
    logic                   at_depth_s;
    logic                   full_s;
    logic                   empty_s;
    logic                   wr_acc_s;
    logic                   pop_s;
    logic                   wr_commit_s;
    logic                   close_commit_s;
    logic                   commit_s;
    logic                   timeout_req_s;
    logic [EW-1:0]          head_s;

    // Occupancy, handshake qualification and commit decisions.
    always_comb begin
        dcnt_s         = wptr_q - rptr_q;
        at_depth_s     = (dcnt_s == DEPTH_P);
        full_s         = at_depth_s | flush;
        empty_s        = (dcnt_s == {PW{1'b0}});
        wr_acc_s       = wren & ~full_s;
        pop_s          = rden & ~empty_s;
        // A write closes the run when the word differs or the count is saturated.
        wr_commit_s    = wr_acc_s & run_open_q &
                         ((din != run_data_q) | (run_cnt_q == RMAX));
        // Flush/timeout close only when the storage has room; otherwise they wait.
        close_commit_s = (flush | timeout_req_s) & run_open_q & ~at_depth_s;
        commit_s       = wr_commit_s | close_commit_s;
        head_s         = mem_q[rptr_q[AW-1:0]];
    end

    // Next state of the open-run register and the FIFO pointers.
    always_comb begin
        run_data_d = run_data_q;
        run_cnt_d  = run_cnt_q;
        run_open_d = run_open_q;
        wptr_d     = wptr_q + (commit_s ? PW'(1) : PW'(0));
        rptr_d     = rptr_q + (pop_s ? PW'(1) : PW'(0));
        if (wr_acc_s) begin
            if (!run_open_q || wr_commit_s) begin
                run_data_d = din;
                run_cnt_d  = CNT_ONE;
                run_open_d = 1'b1;
            end else begin
                run_cnt_d  = run_cnt_q + CNT_ONE;
            end
        end else if (close_commit_s) begin
            run_cnt_d  = {COUNT_WIDTH{1'b0}};
            run_open_d = 1'b0;
        end else begin
            run_open_d = run_open_q;
        end
    end

    // State registers with synchronous active-low reset; storage is not cleared.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q     <= {PW{1'b0}};
            rptr_q     <= {PW{1'b0}};
            run_data_q <= {INPUT_WIDTH{1'b0}};
            run_cnt_q  <= {COUNT_WIDTH{1'b0}};
            run_open_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            run_data_q <= run_data_d;
            run_cnt_q  <= run_cnt_d;
            run_open_q <= run_open_d;
        end
    end

    // Entry storage: the committed (data,count) pair lands at the write pointer.
    always_ff @(posedge clk) begin
        if (commit_s) begin
            mem_q[wptr_q[AW-1:0]] <= {run_data_q, run_cnt_q};
        end
    end

`ifdef UTIL_FIFO_RLE_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);

    logic [IW-1:0] idle_q, idle_d;

    // Timeout request fires on the TIMEOUT-th idle cycle of an open run.
    always_comb begin
        timeout_req_s = run_open_q & ~wr_acc_s & (idle_q == IDLE_LAST);
    end

    // Idle counter: restarts on write or commit, holds at the limit while blocked.
    always_comb begin
        if (wr_acc_s || commit_s) begin
            idle_d = {IW{1'b0}};
        end else if (run_open_q && (idle_q != IDLE_LAST)) begin
            idle_d = idle_q + IW'(1);
        end else begin
            idle_d = idle_q;
        end
    end

    // Idle counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idle_q <= {IW{1'b0}};
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    // Without the timeout feature, only writes and flush close a run.
    always_comb begin
        timeout_req_s = 1'b0;
    end
`endif

    // Output mapping; dout/dnum are show-ahead from the head entry.
    always_comb begin
        full     = full_s;
        empty    = empty_s;
        dcnt     = dcnt_s;
        run_open = run_open_q;
        dout     = head_s[EW-1:COUNT_WIDTH];
        dnum     = head_s[COUNT_WIDTH-1:0];
    end

endmodule

// File: tb/tb_util_fifo_rle.sv
// Self-checking bench for util_fifo_rle (INPUT_WIDTH=8, COUNT_WIDTH=2,
// DEPTH=4). A vector table carries inputs and expected status; entries a
// vector is expected to commit are pushed to a scoreboard queue and checked
// against dout/dnum when a pop is driven.
module tb_util_fifo_rle;

    logic       clk;
    logic       rst_n;
    logic [7:0] din;
    logic       wren;
    logic       flush;
    logic       full;
    logic [7:0] dout;
    logic [1:0] dnum;
    logic       rden;
    logic       empty;
    logic [2:0] dcnt;
    logic       run_open;

`ifdef UTIL_FIFO_RLE_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    util_fifo_rle #(
        .INPUT_WIDTH(8),
        .COUNT_WIDTH(2),
        .DEPTH      (4),
        .TIMEOUT    (16)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .din     (din),
        .wren    (wren),
        .flush   (flush),
        .full    (full),
        .dout    (dout),
        .dnum    (dnum),
        .rden    (rden),
        .empty   (empty),
        .dcnt    (dcnt),
        .run_open(run_open)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       wr;
        logic [7:0] d;
        logic       fl;
        logic       rd;
        logic       x_full;
        logic       x_empty;
        logic [2:0] x_dcnt;
        logic       x_ro;
        logic       cm;
        logic [7:0] cd;
        logic [1:0] cn;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic [1:0] n;
    } ent_t;

    vec_t tbl[$];
    ent_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(input logic rst, input logic wr, input logic [7:0] d,
                                input logic fl, input logic rd, input logic xf,
                                input logic xe, input logic [2:0] xd, input logic xro,
                                input logic cm, input logic [7:0] cd, input logic [1:0] cn);
        vec_t v;
        v.rst = rst; v.wr = wr; v.d = d; v.fl = fl; v.rd = rd;
        v.x_full = xf; v.x_empty = xe; v.x_dcnt = xd; v.x_ro = xro;
        v.cm = cm; v.cd = cd; v.cn = cn;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (vector %0d)", nm, act, exp, n_vec);
        end
    endtask

    // Drive one vector, check pre-edge outputs, clock it, check post-edge state.
    task automatic apply(input vec_t v);
        ent_t e;
        rst_n = ~v.rst;
        wren  = v.wr;
        din   = v.d;
        flush = v.fl;
        rden  = v.rd;
        #1;
        n_vec++;
        check("full", {31'd0, full}, {31'd0, v.x_full});
        if (v.rd && sb.size() > 0) begin
            e = sb.pop_front();
            check("dout", {24'd0, dout}, {24'd0, e.d});
            check("dnum", {30'd0, dnum}, {30'd0, e.n});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wren  = 1'b0;
        flush = 1'b0;
        rden  = 1'b0;
        check("empty", {31'd0, empty}, {31'd0, v.x_empty});
        check("dcnt", {29'd0, dcnt}, {29'd0, v.x_dcnt});
        check("run_open", {31'd0, run_open}, {31'd0, v.x_ro});
        if (v.rst) sb.delete();
        if (v.cm) sb.push_back('{v.cd, v.cn});
    endtask

    initial begin
        logic       fired;
        logic [7:0] ca, cb, cx;
        ca = 8'hA1; cb = 8'hB2; cx = 8'h5C;
        rst_n = 1'b0; wren = 1'b0; din = 8'h00; flush = 1'b0; rden = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        //              rst  wr  d      fl   rd   full empty dcnt  ro   cm  cd     cn
        // reset holds state empty; full follows flush
        tbl.push_back(mk(1'b1,1'b0,8'h00,1'b1,1'b0, 1'b1,1'b1,3'd0,1'b0, 1'b0,8'h00,2'd0));
        // A,A,A,B then flush, pop twice, then pop on empty
        tbl.push_back(mk(1'b0,1'b1,ca,   1'b0,1'b0, 1'b0,1'b1,3'd0,1'b1, 1'b0,8'h00,2'd0));
        tbl.push_back(mk(1'b0,1'b1,ca,   1'b0,1'b0, 1'b0,1'b1,3'd0,1'b1, 1'b0,8'h00,2'd0));
        tbl.push_back(mk(1'b0,1'b1,ca,   1'b0,1'b0, 1'b0,1'b1,3'd0,1'b1, 1'b0,8'h00,2'd0));
        tbl.push_back(mk(1'b0,1'b1,cb,   1'b0,1'b0, 1'b0,1'b0,3'd1,1'b1, 1'b1,ca,   2'd3));
        tbl.push_back(mk(1'b0,1'b0,8'h00,1'b1,1'b0, 1'b1,1'b0,3'd2,1'b0, 1'b1,cb,   2'd1));
        tbl.push_back(mk(1'b0,1'b0,8'h00,1'b0,1'b1, 1'b0,1'b0,3'd1,1'b0, 1'b0,8'h00,2'd0));
        tbl.push_back(mk(1'b0,1'b0,8'h00,1'b0,1'b1, 1'b0,1'b1,3'd0,1'b0, 1'b0,8'h00,2'd0));
        tbl.push_back(mk(1'b0,1'b0,8'h00,1'b0,1'b1, 1'b0,1'b1,3'd0,1'b0, 1'b0,8'h00,2'd0));
        // X seven times with RMAX=3, then flush -> (X,3),(X,3),(X,1)
        tbl.push_back(mk(1'b0,1'b1,cx,   1'b0,1'b0, 1'b0,1'b1,3'd0,1'b1, 1'b0,8'h00,2'd0));
        tbl.push_back(mk(1'b0,1'b1,cx,   1'b0,1'b0, 1'b0,1'b1,3'd0,1'b1, 1'b0,8'h00,2'd0));
        tbl.push_back(mk(1'b0,1'b1,cx,   1'b0,1'b0, 1'b0,1'b1,3'd0,1'b1, 1'b0,8'h00,2'd0));
        tbl.push_back(mk(1'b0,1'b1,cx,   1'b0,1'b0, 1'b0,1'b0,3'd1,1'b1, 1'b1,cx,   2'd3));
        tbl.push_back(mk(1'b0,1'b1,cx,   1'b0,1'b0, 1'b0,1'b0,3'd1,1'b1, 1'b0,8'h00,2'd0));
        tbl.push_back(mk(1'b0,1'b1,cx,   1'b0,1'b0, 1'b0,1'b0,3'd1,1'b1, 1'b0,8'h00,2'd0));
        tbl.push_back(mk(1'b0,1'b1,cx,   1'b0,1'b0, 1'b0,1'b0,3'd2,1'b1, 1'b1,cx,   2'd3));
        tbl.push_back(mk(1'b0,1'b0,8'h00,1'b1,1'b0, 1'b1,1'b0,3'd3,1'b0, 1'b1,cx,   2'd1));
        tbl.push_back(mk(1'b0,1'b0,8'h00,1'b0,1'b1, 1'b0,1'b0,3'd2,1'b0, 1'b0,8'h00,2'd0));
        tbl.push_back(mk(1'b0,1'b0,8'h00,1'b0,1'b1, 1'b0,1'b0,3'd1,1'b0, 1'b0,8'h00,2'd0));
        tbl.push_back(mk(1'b0,1'b0,8'h00,1'b0,1'b1, 1'b0,1'b1,3'd0,1'b0, 1'b0,8'h00,2'd0));
        // write 1..6 into DEPTH=4: full at dcnt=4 with 5 open, 6 refused
        tbl.push_back(mk(1'b0,1'b1,8'h01,1'b0,1'b0, 1'b0,1'b1,3'd0,1'b1, 1'b0,8'h00,2'd0));
        tbl.push_back(mk(1'b0,1'b1,8'h02,1'b0,1'b0, 1'b0,1'b0,3'd1,1'b1, 1'b1,8'h01,2'd1));
        tbl.push_back(mk(1'b0,1'b1,8'h03,1'b0,1'b0, 1'b0,1'b0,3'd2,1'b1, 1'b1,8'h02,2'd1));
        tbl.push_back(mk(1'b0,1'b1,8'h04,1'b0,1'b0, 1'b0,1'b0,3'd3,1'b1, 1'b1,8'h03,2'd1));
        tbl.push_back(mk(1'b0,1'b1,8'h05,1'b0,1'b0, 1'b0,1'b0,3'd4,1'b1, 1'b1,8'h04,2'd1));
        tbl.push_back(mk(1'b0,1'b1,8'h06,1'b0,1'b0, 1'b1,1'b0,3'd4,1'b1, 1'b0,8'h00,2'd0));
        // flush at dcnt=DEPTH has no effect
        tbl.push_back(mk(1'b0,1'b0,8'h00,1'b1,1'b0, 1'b1,1'b0,3'd4,1'b1, 1'b0,8'h00,2'd0));
        // one pop, then 6 accepted on retry (commits 5)
        tbl.push_back(mk(1'b0,1'b0,8'h00,1'b0,1'b1, 1'b1,1'b0,3'd3,1'b1, 1'b0,8'h00,2'd0));
        tbl.push_back(mk(1'b0,1'b1,8'h06,1'b0,1'b0, 1'b0,1'b0,3'd4,1'b1, 1'b1,8'h05,2'd1));
        // write while full with a pop: write refused, pop proceeds
        tbl.push_back(mk(1'b0,1'b1,8'h07,1'b0,1'b1, 1'b1,1'b0,3'd3,1'b1, 1'b0,8'h00,2'd0));
        // commit and pop in the same cycle: dcnt unchanged, oldest leaves, new at tail
        tbl.push_back(mk(1'b0,1'b1,8'h07,1'b0,1'b1, 1'b0,1'b0,3'd3,1'b1, 1'b1,8'h06,2'd1));
        tbl.push_back(mk(1'b0,1'b0,8'h00,1'b1,1'b1, 1'b1,1'b0,3'd3,1'b0, 1'b1,8'h07,2'd1));
        tbl.push_back(mk(1'b0,1'b0,8'h00,1'b0,1'b1, 1'b0,1'b0,3'd2,1'b0, 1'b0,8'h00,2'd0));
        tbl.push_back(mk(1'b0,1'b0,8'h00,1'b0,1'b1, 1'b0,1'b0,3'd1,1'b0, 1'b0,8'h00,2'd0));
        tbl.push_back(mk(1'b0,1'b0,8'h00,1'b0,1'b1, 1'b0,1'b1,3'd0,1'b0, 1'b0,8'h00,2'd0));
        // reset with run open and dcnt=2 discards everything; then C + flush
        tbl.push_back(mk(1'b0,1'b1,8'h11,1'b0,1'b0, 1'b0,1'b1,3'd0,1'b1, 1'b0,8'h00,2'd0));
        tbl.push_back(mk(1'b0,1'b1,8'h22,1'b0,1'b0, 1'b0,1'b0,3'd1,1'b1, 1'b1,8'h11,2'd1));
        tbl.push_back(mk(1'b0,1'b1,8'h33,1'b0,1'b0, 1'b0,1'b0,3'd2,1'b1, 1'b1,8'h22,2'd1));
        tbl.push_back(mk(1'b1,1'b0,8'h00,1'b0,1'b0, 1'b0,1'b1,3'd0,1'b0, 1'b0,8'h00,2'd0));
        tbl.push_back(mk(1'b0,1'b1,8'hCC,1'b0,1'b0, 1'b0,1'b1,3'd0,1'b1, 1'b0,8'h00,2'd0));
        tbl.push_back(mk(1'b0,1'b0,8'h00,1'b1,1'b0, 1'b1,1'b0,3'd1,1'b0, 1'b1,8'hCC,2'd1));
        tbl.push_back(mk(1'b0,1'b0,8'h00,1'b0,1'b1, 1'b0,1'b1,3'd0,1'b0, 1'b0,8'h00,2'd0));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
        end

        // Idle timeout: write D, then 20 idle cycles. With the feature, the run
        // commits on the 16th idle edge; without it the run stays open.
        apply(mk(1'b0,1'b1,8'hDD,1'b0,1'b0, 1'b0,1'b1,3'd0,1'b1, 1'b0,8'h00,2'd0));
        for (int k = 1; k <= 20; k++) begin
            fired = TO_EN && (k >= 16);
            apply(mk(1'b0,1'b0,8'h00,1'b0,1'b0, 1'b0, ~fired, fired ? 3'd1 : 3'd0, ~fired,
                     TO_EN && (k == 16), 8'hDD, 2'd1));
        end
        // flush commits (D,1) only if the timeout has not already done so
        apply(mk(1'b0,1'b0,8'h00,1'b1,1'b0, 1'b1,1'b0,3'd1,1'b0, ~TO_EN,8'hDD,2'd1));
        apply(mk(1'b0,1'b0,8'h00,1'b0,1'b1, 1'b0,1'b1,3'd0,1'b0, 1'b0,8'h00,2'd0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
